// File: rtl/gpio_pio_pkg.sv
// Shared definitions for the parametrised GPIO/PIO block: the register map and
// the debounce counter sizing helper.
package gpio_pio_pkg;

  localparam logic [2:0] ADDR_DATA_IN   = 3'd0;
  localparam logic [2:0] ADDR_DATA_OUT  = 3'd1;
  localparam logic [2:0] ADDR_OUT_SET   = 3'd2;
  localparam logic [2:0] ADDR_OUT_CLR   = 3'd3;
  localparam logic [2:0] ADDR_IRQ_MASK  = 3'd4;
  localparam logic [2:0] ADDR_EDGE_CAP  = 3'd5;
  localparam logic [2:0] ADDR_EDGE_RISE = 3'd6;
  localparam logic [2:0] ADDR_EDGE_FALL = 3'd7;

  // Width of a counter holding 0..cycles, never narrower than one bit.
  function automatic int debounce_cnt_w(input int cycles);
    return (cycles < 1) ? 1 : $clog2(cycles + 1);
  endfunction

endpackage

// File: rtl/gpio_debounce.sv
// Single-bit input conditioner: 2-FF synchroniser followed by an optional
// stable-for-N-cycles debounce filter.
module gpio_debounce
  import gpio_pio_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 0
) (
  input  logic clk,
  input  logic reset,
  input  logic pin,
  output logic filtered
);

  logic sync1;
  logic sync2;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= pin;
      sync2 <= sync1;
    end
  end

  generate
    if (DEBOUNCE_CYCLES == 0) begin : g_bypass
      assign filtered = sync2;
    end else begin : g_filter
      localparam int CW = debounce_cnt_w(DEBOUNCE_CYCLES);
      localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

      logic [CW-1:0] cnt;
      logic          filt;

      // The filter flips on the edge where the count would reach DEBOUNCE_CYCLES,
      // giving a pin-to-filtered latency of exactly 2 + DEBOUNCE_CYCLES.
      always_ff @(posedge clk) begin
        if (reset) begin
          cnt  <= '0;
          filt <= 1'b0;
        end else if (sync2 == filt) begin
          cnt <= '0;
        end else if (cnt == LAST) begin
          filt <= sync2;
          cnt  <= '0;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end

      assign filtered = filt;
    end
  endgenerate

endmodule

// File: rtl/gpio_pio_ext.sv
// Avalon-MM GPIO block: debounced input bank with edge capture and maskable
// level interrupt, plus an output bank with atomic set/clear.
module gpio_pio_ext
  import gpio_pio_pkg::*;
#(
  parameter int                IN_W            = 14,
  parameter int                OUT_W           = 10,
  parameter int                DEBOUNCE_CYCLES = 0,
  parameter logic [OUT_W-1:0]  OUT_RESET       = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [2:0]       avs_address,
  input  logic             avs_read,
  input  logic             avs_write,
  input  logic [31:0]      avs_writedata,
  output logic [31:0]      avs_readdata,
  input  logic [IN_W-1:0]  gpio_in,
  output logic [OUT_W-1:0] gpio_out,
  output logic             irq
);

  logic [IN_W-1:0]  filtered;
  logic [IN_W-1:0]  filtered_d;
  logic [IN_W-1:0]  irq_mask;
  logic [IN_W-1:0]  edge_cap;
  logic [IN_W-1:0]  edge_rise;
  logic [IN_W-1:0]  edge_fall;
  logic [IN_W-1:0]  cap_set;
  logic [IN_W-1:0]  cap_clr;
  logic [IN_W-1:0]  wd_in;
  logic [OUT_W-1:0] wd_out;
  logic [31:0]      rd_mux;
  logic             unused_wd;

  for (genvar i = 0; i < IN_W; i++) begin : g_in
    gpio_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk      (clk),
      .reset    (reset),
      .pin      (gpio_in[i]),
      .filtered (filtered[i])
    );
  end

  assign wd_in     = avs_writedata[IN_W-1:0];
  assign wd_out    = avs_writedata[OUT_W-1:0];
  assign unused_wd = ^avs_writedata;

  assign cap_set = (filtered & ~filtered_d & edge_rise) | (~filtered & filtered_d & edge_fall);
  assign cap_clr = (avs_write && avs_address == ADDR_EDGE_CAP) ? wd_in : '0;

  // NOTE: default every combinational output first so no path can infer a latch.
  always_comb begin
    rd_mux = '0;
    case (avs_address)
      ADDR_DATA_IN:   rd_mux[IN_W-1:0]  = filtered;
      ADDR_DATA_OUT:  rd_mux[OUT_W-1:0] = gpio_out;
      ADDR_IRQ_MASK:  rd_mux[IN_W-1:0]  = irq_mask;
      ADDR_EDGE_CAP:  rd_mux[IN_W-1:0]  = edge_cap;
      ADDR_EDGE_RISE: rd_mux[IN_W-1:0]  = edge_rise;
      ADDR_EDGE_FALL: rd_mux[IN_W-1:0]  = edge_fall;
      default:        rd_mux            = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      avs_readdata <= '0;
      gpio_out     <= OUT_RESET;
      irq          <= 1'b0;
      filtered_d   <= '0;
      irq_mask     <= '0;
      edge_cap     <= '0;
      edge_rise    <= '0;
      edge_fall    <= '0;
    end else begin
      filtered_d <= filtered;
      irq        <= |(edge_cap & irq_mask);
      // A new edge outranks a simultaneous write-1-to-clear.
      edge_cap   <= (edge_cap & ~cap_clr) | cap_set;
      if (avs_read) begin
        avs_readdata <= rd_mux;
      end
      if (avs_write) begin
        case (avs_address)
          ADDR_DATA_OUT:  gpio_out  <= wd_out;
          ADDR_OUT_SET:   gpio_out  <= gpio_out | wd_out;
          ADDR_OUT_CLR:   gpio_out  <= gpio_out & ~wd_out;
          ADDR_IRQ_MASK:  irq_mask  <= wd_in;
          ADDR_EDGE_RISE: edge_rise <= wd_in;
          ADDR_EDGE_FALL: edge_fall <= wd_in;
          default:        ;
        endcase
      end
    end
  end

endmodule
